// File: rtl/arb_pkg.sv
// Shared definitions for the request arbiter family.
// Mode encodings, hold counter width and a width helper.
package arb_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;
    localparam int   HOLD_CW   = 8;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating priority picker.
// Searches req upward from start, wrapping via a doubled vector.
module arb_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    always_comb begin
        dbl = {req, req};
        rot = dbl[int'(start) +: N];
        any = |req;
        off = '0;
        // descending scan so the lowest set offset wins
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = IDW'(j);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
        idx = sum[IDW-1:0];
        win = '0;
        win[idx] = any;
    end

endmodule

// File: rtl/rr_fixed_arbiter.sv
// N-requester arbiter, fixed or round-robin priority,
// registered one-hot grant with bounded grant lock.
module rr_fixed_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           mode,
    input  logic           hold_en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    localparam logic [HOLD_CW-1:0] LIM = HOLD_CW'(MAX_HOLD - 1);

    logic [IDW-1:0]     rr_ptr;
    logic [HOLD_CW-1:0] hold_cnt;
    logic               lock_hit;
    logic               expire;
    logic [N-1:0]       pick_req;
    logic [IDW-1:0]     start;
    logic [N-1:0]       p_gnt;
    logic [IDW-1:0]     p_id;
    logic               p_any;
    logic [IDW-1:0]     sel_id;
    logic [IDW-1:0]     ptr_nxt;

    always_comb begin
        lock_hit = hold_en && gnt_valid && req[gnt_id];
        expire   = lock_hit && (hold_cnt >= LIM);
        // at expiry the holder competes only if nobody else asks
        pick_req = expire ? (req & ~gnt) : req;
        start    = (mode == ARB_RR) ? rr_ptr : '0;
        sel_id   = p_any ? p_id : gnt_id;
        ptr_nxt  = (sel_id == IDW'(N - 1)) ? '0
                 : sel_id + IDW'(1);
    end

    arb_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (pick_req),
        .start (start),
        .win   (p_gnt),
        .idx   (p_id),
        .any   (p_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
        end else if (lock_hit && !expire) begin
            hold_cnt <= hold_cnt + HOLD_CW'(1);
        end else if (expire && !p_any) begin
            hold_cnt <= '0;
            rr_ptr   <= ptr_nxt;
        end else if (p_any) begin
            gnt       <= p_gnt;
            gnt_id    <= p_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            rr_ptr    <= ptr_nxt;
        end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_rr_fixed_arbiter.sv
// Scoreboard bench for rr_fixed_arbiter, N=4.
// Two instances share stimulus: MAX_HOLD=3 and MAX_HOLD=4.
module tb_rr_fixed_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       mode;
    logic       hold_en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic [3:0] gnt4;
    logic [1:0] gnt_id4;
    logic       gnt_valid4;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       c4;
        logic [3:0] g4;
        logic [1:0] id4;
        logic       v4;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    rr_fixed_arbiter #(.N(4), .MAX_HOLD(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .hold_en   (hold_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    rr_fixed_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .hold_en   (hold_en),
        .gnt       (gnt4),
        .gnt_id    (gnt_id4),
        .gnt_valid (gnt_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [6:0] act,
                       input logic [6:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got gnt/id/v=%b_%b_%b want %b_%b_%b",
                     nm, act[6:3], act[2:1], act[0],
                     want[6:3], want[2:1], want[0]);
        end
    endtask

    // monitor: one output word per cycle, #1 after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && sb.size() > 0) begin
                e = sb.pop_front();
                chk("dut_mh3", {gnt, gnt_id, gnt_valid},
                    {e.g, e.id, e.v});
                if (e.c4)
                    chk("dut_mh4", {gnt4, gnt_id4, gnt_valid4},
                        {e.g4, e.id4, e.v4});
            end
        end
    end

    task automatic step4(input logic [3:0] r, input logic m,
                         input logic h, input logic [3:0] g,
                         input logic [1:0] id, input logic v,
                         input logic c4, input logic [3:0] g4,
                         input logic [1:0] id4, input logic v4);
        exp_t e;
        req     = r;
        mode    = m;
        hold_en = h;
        e = '{g: g, id: id, v: v, c4: c4,
              g4: g4, id4: id4, v4: v4};
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic [3:0] r, input logic m,
                        input logic h, input logic [3:0] g,
                        input logic [1:0] id, input logic v);
        step4(r, m, h, g, id, v, 1'b0, 4'b0, 2'b0, 1'b0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        req     = 4'b0;
        mode    = 1'b0;
        hold_en = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_state", {gnt, gnt_id, gnt_valid}, 7'b0);
        reset = 1'b1;

        // fixed priority, no lock
        step(4'b1010, 0, 0, 4'b0010, 2'd1, 1);
        step(4'b1010, 0, 0, 4'b0010, 2'd1, 1);
        step(4'b1010, 0, 0, 4'b0010, 2'd1, 1);
        step(4'b1000, 0, 0, 4'b1000, 2'd3, 1);
        step(4'b0000, 0, 0, 4'b0000, 2'd3, 0);

        // round robin, no lock, two full rotations
        step(4'b1111, 1, 0, 4'b0001, 2'd0, 1);
        step(4'b1111, 1, 0, 4'b0010, 2'd1, 1);
        step(4'b1111, 1, 0, 4'b0100, 2'd2, 1);
        step(4'b1111, 1, 0, 4'b1000, 2'd3, 1);
        step(4'b1111, 1, 0, 4'b0001, 2'd0, 1);
        step(4'b1111, 1, 0, 4'b0010, 2'd1, 1);
        step(4'b1111, 1, 0, 4'b0100, 2'd2, 1);
        step(4'b1111, 1, 0, 4'b1000, 2'd3, 1);
        step(4'b0000, 1, 0, 4'b0000, 2'd3, 0);

        // round robin with lock, MAX_HOLD=3
        step(4'b0011, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0011, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0011, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0011, 1, 1, 4'b0010, 2'd1, 1);
        step(4'b0011, 1, 1, 4'b0010, 2'd1, 1);
        step(4'b0011, 1, 1, 4'b0010, 2'd1, 1);
        step(4'b0011, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0001, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0001, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0001, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0001, 1, 1, 4'b0001, 2'd0, 1);

        // lock release without bubble
        step(4'b0000, 1, 1, 4'b0000, 2'd0, 0);
        step(4'b0100, 1, 1, 4'b0100, 2'd2, 1);
        step(4'b0101, 1, 1, 4'b0100, 2'd2, 1);
        step(4'b0001, 1, 1, 4'b0001, 2'd0, 1);
        step(4'b0000, 1, 1, 4'b0000, 2'd0, 0);

        // reset asserted between edges while gnt=0100
        step(4'b0100, 1, 1, 4'b0100, 2'd2, 1);
        step(4'b0100, 1, 1, 4'b0100, 2'd2, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset", {gnt, gnt_id, gnt_valid}, 7'b0);
        sb.delete();
        @(posedge clk);
        #2;
        chk("reset_hold", {gnt, gnt_id, gnt_valid}, 7'b0);
        chk("reset_hold4", {gnt4, gnt_id4, gnt_valid4}, 7'b0);
        reset = 1'b1;

        // rr restarts at 0, then a fixed lock survives a mode switch
        step4(4'b1111, 1, 0, 4'b0001, 2'd0, 1, 1, 4'b0001, 2'd0, 1);
        step4(4'b1000, 0, 1, 4'b1000, 2'd3, 1, 1, 4'b1000, 2'd3, 1);
        step4(4'b1111, 1, 1, 4'b1000, 2'd3, 1, 1, 4'b1000, 2'd3, 1);
        step4(4'b1111, 1, 1, 4'b1000, 2'd3, 1, 1, 4'b1000, 2'd3, 1);
        step4(4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1, 4'b1000, 2'd3, 1);
        step4(4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1, 4'b0001, 2'd0, 1);
        step4(4'b1111, 1, 1, 4'b0001, 2'd0, 1, 1, 4'b0001, 2'd0, 1);
        step4(4'b0000, 1, 1, 4'b0000, 2'd0, 0, 1, 4'b0000, 2'd0, 0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_fixed_arbiter.md
Name: rr_fixed_arbiter

Overview:
- Parametrised N-requester arbiter with registered one-hot grant; successor to the 4-input fixed-priority arbiter.
- Runtime-selectable fixed-priority or round-robin mode.
- Grant lock: a granted requester holds the grant while its request stays high, bounded by a programmable maximum hold length.
- Sits in front of shared resources (bus, memory port, FIFO write side) as the standard arbiter for the design.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant; legal range 1..255.
- IDW, $clog2(N), width of gnt_id; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; asserts asynchronously, is released synchronously to clk.
- req  input  N  request vector; bit i is requester i.
- mode  input  1  0 = fixed priority (index 0 highest, N-1 lowest); 1 = round robin.
- hold_en  input  1  1 = grant lock enabled; 0 = re-arbitrate every cycle.
- gnt  output  N  registered one-hot grant; all zeros when idle.
- gnt_id  output  IDW  binary index of the granted requester; valid only when gnt_valid = 1.
- gnt_valid  output  1  high when gnt is non-zero.

Behaviour:
Reset values:
- gnt = 0, gnt_id = 0, gnt_valid = 0, rr_ptr = 0, hold_cnt = 0.
- Reset mid-operation clears any grant immediately (asynchronously).

Latency and outputs:
- One cycle: req sampled at edge k drives gnt, gnt_id and gnt_valid after edge k.
- All three outputs change only on clk edges and are mutually consistent.

Internal state:
- rr_ptr: IDW bits, the index holding highest priority in round-robin mode.
- hold_cnt: 8 bits, counts the cycles the current holder has held the grant.

Each-cycle decision, evaluated in this order:
1. Lock continue: hold_en = 1, gnt_valid = 1, req[gnt_id] = 1 and hold_cnt < MAX_HOLD-1.
   - Keep gnt unchanged; hold_cnt increments.
2. Lock expiry: as case 1, but hold_cnt = MAX_HOLD-1.
   - Re-arbitrate with the holder masked out of req.
   - If the masked vector is non-zero: grant the winner and set hold_cnt = 0.
   - If the masked vector is zero: the holder keeps the grant and hold_cnt = 0. The lock restarts with no bubble.
3. Otherwise, arbitrate over req:
   - Fixed mode: grant the lowest set index.
   - Round-robin mode: grant the first set index searching upward from rr_ptr, wrapping from N-1 to 0.
   - If req = 0: gnt = 0, gnt_valid = 0, and gnt_id retains its last value.
   - hold_cnt = 0 on every new grant.

Holder release and hold_en:
- When the holder drops req, the next cycle is a normal arbitration. There is no idle bubble if other requests are pending.
- hold_en = 0 forces case 3 every cycle; hold_cnt is held at 0.

rr_ptr update:
- On every grant to index g, in either mode: rr_ptr = (g+1) mod N.
- Wrap: g = N-1 gives rr_ptr = 0.
- rr_ptr does not change while idle.

Mode switching:
- A mode change takes effect at the next arbitration decision (cases 2 or 3).
- A lock in progress is not broken by a mode change.

Guarantees:
- gnt is never non-one-hot.
- gnt never names a requester whose req was 0 at the sampling edge.
- Fixed mode may starve low-priority requesters; this is intended. Round-robin mode bounds the wait to (N-1)*MAX_HOLD cycles.

Decomposition:
- Package arb_pkg holds:
  - The clog2 helper.
  - Mode encoding constants ARB_FIXED = 1'b0, ARB_RR = 1'b1.
  - HOLD_CW = 8.
- One sub-module: arb_pick. It is a combinational masked priority picker.
  - Inputs: req vector and start index.
  - Outputs: one-hot winner, binary index, any-valid flag.
  - Fixed mode uses start index 0. Round robin uses rr_ptr. Implement as a doubled-vector search.
- The top level holds rr_ptr, hold_cnt, the lock/expiry decision and the output registers.

Test Plan:
- Fixed mode, hold_en = 0, N = 4, req = 4'b1010 for 3 cycles: gnt = 4'b0010, gnt_id = 1 every cycle. Then req = 4'b1000: gnt = 4'b1000 one cycle later.
- Round-robin mode, hold_en = 0, req = 4'b1111 held: gnt sequence 0001, 0010, 0100, 1000, 0001 (wrap), one grant per cycle.
- Round-robin mode, hold_en = 1, MAX_HOLD = 3, req = 4'b0011 constant:
  - gnt = 0001 for 3 cycles, then 0010 for 3 cycles, then 0001 again.
  - With req = 4'b0001 alone, gnt stays 0001 continuously with no bubble.
- Lock release: holder 2 drops req after 1 cycle while req[0] = 1. gnt switches to 0001 on the next edge with no zero cycle. Idle req = 0 gives gnt = 0 and gnt_valid = 0.
- Reset mid-grant: assert reset while gnt = 0100, asynchronously between edges. Outputs clear immediately.
  - After release, round robin with req = 1111 restarts at gnt = 0001 (rr_ptr = 0).
- Mode switch during lock: a fixed-mode lock on index 3 (MAX_HOLD = 4) is kept through a switch to round robin. At expiry, with req = 1111, gnt = 0001 (rr_ptr wrapped to 0).
